vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
//   Free-running 640x480@60 VGA timing generator with built-in colour-bar test pattern.
//   Derives pixel clock PCK from system clock CLK.
//   Drives 24-bit RGB with HS/VS/DE for a display or downstream video encoder.
//   Standalone top-level stimulus source; no inputs besides clock/reset.
// PARAMETERS
//   CLK_DIV   5    CLK cycles per pixel (125 MHz -> 25 MHz PCK); must be >= 2
//   H_ACTIVE  640  visible pixels per line
//   H_FP      16   horizontal front porch, pixels
//   H_SYNC    96   horizontal sync width, pixels
//   H_BP      48   horizontal back porch, pixels (line total 800)
//   V_ACTIVE  480  visible lines per frame
//   V_FP      10   vertical front porch, lines
//   V_SYNC    2    vertical sync width, lines
//   V_BP      33   vertical back porch, lines (frame total 525)
// PORTS
//   CLK     in   1  system clock; all logic on rising edge
//   RST     in   1  asynchronous, active-high reset
//   VGA_R   out  8  red, 0 when VGA_DE=0
//   VGA_G   out  8  green, 0 when VGA_DE=0
//   VGA_B   out  8  blue, 0 when VGA_DE=0
//   VGA_HS  out  1  horizontal sync, active low
//   VGA_VS  out  1  vertical sync, active low
//   VGA_DE  out  1  data enable, high during visible pixels
//   PCK     out  1  pixel clock, registered from CLK divider
// BEHAVIOUR
//   - Reset (async assert, sync release): div=0, hcnt=0, vcnt=0, PCK=0, VGA_HS=1, VGA_VS=1,
//     VGA_DE=0, RGB=0. Reset mid-frame aborts the frame; timing restarts at (0,0).
//   - Divider: div counts 0..CLK_DIV-1, wraps. PCK=1 for div<CLK_DIV/2 (floor), else 0
//     (CLK_DIV=5: high 2 CLK, low 3 CLK). PCK registered, glitch-free.
//   - Pixel tick: the CLK edge where div becomes CLK_DIV/2 (PCK falling). Counters and all
//     video outputs change only on pixel ticks, so they are stable at every PCK rising edge.
//   - hcnt 0..799 increments per tick; at 799 wraps to 0 and vcnt increments; vcnt 0..524 wraps to 0.
//   - Output registers, updated on each tick from the counter values before that tick's
//     increment (one-tick latency, identical for DE/HS/VS/RGB):
//       DE = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE)
//       HS = 0 when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751), else 1
//       VS = 0 when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (490..491), else 1
//   - Pattern: 8 vertical bars, each H_ACTIVE/8 = 80 px, index = hcnt/80, {R,G,B} in order:
//     0 FFFFFF white, 1 FFFF00 yellow, 2 00FFFF cyan, 3 00FF00 green,
//     4 FF00FF magenta, 5 FF0000 red, 6 0000FF blue, 7 000000 black.
//     Same on every line and every frame; RGB forced to 0 when DE=0.
//   - Frame = 800*525 = 420000 PCK periods; 640*480 = 307200 DE-high PCK rising edges.
//   - First visible pixel after reset release: line 0, pixel 0 (white), on the first DE-high PCK rise.
// TESTING
//   1 Hold RST 20 CLK, release -> during reset PCK=0, HS=VS=1, DE=0, RGB=0; after release PCK period 5 CLK, high 2.
//   2 Count PCK rising edges with DE=1 per line -> exactly 640 contiguous; per frame 307200; 480 DE lines.
//   3 HS: low for exactly 96 PCK, period 800 PCK, falls 16 PCK after DE falls.
//     VS: low exactly 1600 PCK (2 lines), period 420000 PCK.
//   4 Sample RGB on DE pixels -> px0=FFFFFF, px79=FFFFFF, px80=FFFF00, px320=FF00FF,
//     px560=000000, px639=000000; blanking RGB=0.
//   5 Capture 2 full frames to BMP (BGR order) -> frames bit-identical, 8 bars of 80 px each.
//   6 Assert RST mid-line (vcnt~200) for 3 CLK -> outputs return to reset values at once;
//     next frame starts at line 0 with correct counts.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Free-running VGA timing generator (640x480@60 by default) with an
//   8-bar colour test pattern. A pixel clock PCK is divided down from CLK;
//   all counters and video outputs advance on the CLK edge where PCK falls,
//   so everything is stable at each PCK rising edge.
// Ports
//   CLK               in   system clock, rising edge
//   RST               in   asynchronous active-high reset
//   VGA_R/G/B [7:0]   out  colour, forced to 0 outside the visible area
//   VGA_HS, VGA_VS    out  active-low syncs
//   VGA_DE            out  data enable, high on visible pixels
//   PCK               out  registered pixel clock (high CLK_DIV/2 CLKs)
module vga_pattern_gen #(
   parameter int CLK_DIV  = 5,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       CLK,
   input  logic       RST,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_DE,
   output logic       PCK
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int DW      = $clog2(CLK_DIV);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BW      = $clog2(BAR_W + 1);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   logic [DW-1:0] div, div_nxt;
   logic [HW-1:0] hcnt;
   logic [VW-1:0] vcnt;
   logic [BW-1:0] bar_cnt;
   logic [2:0]    bar_idx;
   logic          tick, de_now, hs_now, vs_now;

   always_comb begin
      div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
      // Pixel tick coincides with PCK going low.
      tick    = (div_nxt == DIV_HALF);
      de_now  = (hcnt < H_ACT) && (vcnt < V_ACT);
      hs_now  = !((hcnt >= HS_BEG) && (hcnt < HS_END));
      vs_now  = !((vcnt >= VS_BEG) && (vcnt < VS_END));
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div <= '0;
         PCK <= 1'b0;
      end else begin
         div <= div_nxt;
         PCK <= (div_nxt < DIV_HALF);
      end
   end

   // Bar index is tracked with a small sub-counter instead of dividing hcnt
   // by the bar width. After the 8th bar it wraps, harmless since DE is low.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hcnt    <= '0;
         vcnt    <= '0;
         bar_cnt <= '0;
         bar_idx <= '0;
         VGA_DE  <= 1'b0;
         VGA_HS  <= 1'b1;
         VGA_VS  <= 1'b1;
         VGA_R   <= '0;
         VGA_G   <= '0;
         VGA_B   <= '0;
      end else if (tick) begin
         VGA_DE <= de_now;
         VGA_HS <= hs_now;
         VGA_VS <= vs_now;
         // Bar colours: R off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
         VGA_R  <= (de_now && !bar_idx[1]) ? 8'hFF : 8'h00;
         VGA_G  <= (de_now && !bar_idx[2]) ? 8'hFF : 8'h00;
         VGA_B  <= (de_now && !bar_idx[0]) ? 8'hFF : 8'h00;

         if (hcnt == H_LAST) begin
            hcnt    <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            vcnt    <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
         end else begin
            hcnt <= hcnt + 1'b1;
            if (bar_cnt == BAR_LAST) begin
               bar_cnt <= '0;
               bar_idx <= bar_idx + 1'b1;
            end else begin
               bar_cnt <= bar_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench: a shrunk-timing instance (24x8 total, 16x4 visible, 2-px bars) is
// checked pixel by pixel over several frames; a default-timing instance is
// checked over its first line and a bit (bar edges, DE/HS placement).
module tb_vga_pattern_gen;

   localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;  // line total 24
   localparam int SVA = 4,  SVF = 1, SVS = 2, SVB = 1;  // frame total 8
   localparam int SHT = 24, SVT = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   logic [7:0] s_r, s_g, s_b, d_r, d_g, d_b;
   logic       s_hs, s_vs, s_de, s_pck, d_hs, d_vs, d_de, d_pck;

   vga_pattern_gen #(
      .CLK_DIV(5), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) u_s (
      .CLK(CLK), .RST(RST), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
      .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_DE(s_de), .PCK(s_pck)
   );

   vga_pattern_gen u_d (
      .CLK(CLK), .RST(RST), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
      .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_DE(d_de), .PCK(d_pck)
   );

   int   errors = 0;
   int   checks = 0;
   logic p_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for the next PCK 0->1 seen at CLK negedges; report CLKs waited and
   // how many of those samples had PCK high.
   task automatic wait_rise(output int n, output int hi);
      logic rose;
      n = 0; hi = 0; rose = 1'b0;
      while (!rose && n < 20) begin
         @(negedge CLK);
         n++;
         if (s_pck === 1'b1) hi++;
         rose   = (s_pck === 1'b1) && (p_prev === 1'b0);
         p_prev = s_pck;
      end
      if (!rose) begin
         checks++;
         errors++;
         $display("FAIL pck_timeout: observed no PCK rise in %0d CLK, expected one within 5", n);
      end
   endtask

   function automatic logic [26:0] model(input int h, input int v, input int ha, input int hfp,
                                         input int hsw, input int va, input int vfp, input int vsw);
      logic de, hs, vs;
      logic [23:0] rgb;
      de = (h < ha) && (v < va);
      hs = !((h >= ha + hfp) && (h < ha + hfp + hsw));
      vs = !((v >= va + vfp) && (v < va + vfp + vsw));
      case (h / (ha / 8))
         0: rgb = 24'hFFFFFF;
         1: rgb = 24'hFFFF00;
         2: rgb = 24'h00FFFF;
         3: rgb = 24'h00FF00;
         4: rgb = 24'hFF00FF;
         5: rgb = 24'hFF0000;
         6: rgb = 24'h0000FF;
         default: rgb = 24'h000000;
      endcase
      if (!de) rgb = 24'h0;
      return {de, hs, vs, rgb};
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_s"}, 32'({s_pck, s_hs, s_vs, s_de, s_r, s_g, s_b}), 32'({4'b0110, 24'h0}));
      chk({tag, "_d"}, 32'({d_pck, d_hs, d_vs, d_de, d_r, d_g, d_b}), 32'({4'b0110, 24'h0}));
   endtask

   // The first PCK rise after reset release precedes the first pixel tick,
   // so outputs still carry reset values there.
   task automatic first_rise();
      int n, hi;
      p_prev = s_pck;
      wait_rise(n, hi);
      chk("rise0_de", 32'({s_de, d_de, s_hs, d_hs}), 32'(4'b0011));
   endtask

   // Rise k (k>=0) after first_rise shows pixel k of the frame.
   task automatic run(input int nrise);
      int n, hi, h, v;
      int de_c = 0, hs_c = 0, vs_c = 0, dde_c = 0, dhs_c = 0, dhs_f = -1;
      for (int k = 0; k < nrise; k++) begin
         wait_rise(n, hi);
         if (k > 0) begin
            chk("pck_period", 32'(n), 32'd5);
            chk("pck_high", 32'(hi), 32'd2);
         end
         h = k % SHT;
         v = (k / SHT) % SVT;
         chk($sformatf("s_px h%0d v%0d", h, v), 32'({s_de, s_hs, s_vs, s_r, s_g, s_b}),
             32'(model(h, v, SHA, SHF, SHS, SVA, SVF, SVS)));
         if (k < 4 * SHT * SVT) begin
            de_c += int'(s_de);
            hs_c += int'(!s_hs);
            vs_c += int'(!s_vs);
         end
         h = k % 800;
         v = k / 800;
         chk($sformatf("d_px h%0d v%0d", h, v), 32'({d_de, d_hs, d_vs, d_r, d_g, d_b}),
             32'(model(h, v, 640, 16, 96, 480, 10, 2)));
         case (k)
            0:   chk("d_px0",   32'({d_r, d_g, d_b}), 32'h00FFFFFF);
            79:  chk("d_px79",  32'({d_r, d_g, d_b}), 32'h00FFFFFF);
            80:  chk("d_px80",  32'({d_r, d_g, d_b}), 32'h00FFFF00);
            320: chk("d_px320", 32'({d_r, d_g, d_b}), 32'h00FF00FF);
            560: chk("d_px560", 32'({d_r, d_g, d_b, d_de}), 32'h00000001);
            639: chk("d_px639", 32'({d_r, d_g, d_b, d_de}), 32'h00000001);
            640: chk("d_px640", 32'({d_r, d_g, d_b, d_de}), 32'h00000000);
            default: ;
         endcase
         if (k < 800) begin
            dde_c += int'(d_de);
            dhs_c += int'(!d_hs);
            if (!d_hs && dhs_f < 0) dhs_f = k;
         end
      end
      chk("s_de_4frames", 32'(de_c), 32'd256);
      chk("s_hs_low_32lines", 32'(hs_c), 32'd96);
      chk("s_vs_low_4frames", 32'(vs_c), 32'd192);
      chk("d_de_line0", 32'(dde_c), 32'd640);
      chk("d_hs_low_line0", 32'(dhs_c), 32'd96);
      chk("d_hs_fall_px", 32'(dhs_f), 32'd656);
   endtask

   initial begin
      RST = 1'b1;
      repeat (20) @(negedge CLK);
      check_reset_vals("reset");
      RST = 1'b0;
      first_rise();
      run(1000);

      // Mid-line reset on the default instance (line 1, pixel ~200).
      @(negedge CLK);
      RST = 1'b1;
      #1;
      check_reset_vals("midrst_now");
      repeat (3) @(negedge CLK);
      check_reset_vals("midrst_hold");
      RST = 1'b0;
      first_rise();
      run(1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
